// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// The master side drives requests and enable; the slave side (arbiter) returns the grant.
interface rr_arbiter4_if;
    logic       en;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output en,
        output req,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant lock; gnt_idx feeds the grant decoder.
// Optional forced rotation after HOLD_MAX grant cycles is enabled by macro ARB_MAX_HOLD_EN.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] gnt_idx_reg, gnt_idx_next;
    logic       gnt_valid_reg, gnt_valid_next;
    logic       preempt_reg, preempt_next;

    logic [3:0] owner_oh;
    logic [3:0] others;
    logic       owner_req;
    logic       forced;
    logic       release_now;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range_check
            $error("rr_arbiter4: HOLD_MAX must be within 2..255");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_owner
            assign owner_oh[gi] = (gnt_idx_reg == 2'(gi));
        end
    endgenerate

    // First set bit scanning ptr+1, ptr+2, ptr+3, ptr; the pointer itself is last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign owner_req = bus.req[gnt_idx_reg];
    assign others    = bus.req & ~owner_oh;

`ifdef ARB_MAX_HOLD_EN
    logic [7:0] hold_cnt_reg, hold_cnt_next;

    assign forced = (state_reg == GRANT) && owner_req && (hold_cnt_reg == 8'(HOLD_MAX - 1));

    // Any path out of a plain hold (new grant, forced keep, return to idle) restarts the count.
    always_comb begin
        hold_cnt_next = 8'd0;
        if (state_reg == GRANT && !release_now) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= 8'd0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end
`else
    assign forced = 1'b0;
`endif

    assign release_now = !owner_req || forced;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_valid_next = gnt_valid_reg;
        preempt_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.en && |bus.req) begin
                    gnt_idx_next   = pick(bus.req, ptr_reg);
                    gnt_valid_next = 1'b1;
                    state_next     = GRANT;
                end else begin
                    gnt_valid_next = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_next = gnt_idx_reg;
                    // Owner is masked out, so it cannot win back-to-back even when forced.
                    if (bus.en && |others) begin
                        gnt_idx_next = pick(others, gnt_idx_reg);
                        preempt_next = forced;
                    end else if (!forced) begin
                        state_next     = IDLE;
                        gnt_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                gnt_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd3;
            gnt_idx_reg   <= 2'd0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            preempt_reg   <= preempt_next;
        end
    end

    assign bus.gnt_idx   = gnt_idx_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.preempt   = preempt_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4 (HOLD_MAX=4); expectations follow ARB_MAX_HOLD_EN.
module tb_rr_arbiter4;

`ifdef ARB_MAX_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       v;
        logic [1:0] i;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input string tag, input logic v, input logic [1:0] i, input logic p);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.i   = i;
        e.p   = p;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got %0d entries expected >0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("t=%0t %s req=%b en=%b -> valid=%b idx=%0d preempt=%b", $time, e.tag,
                     bus.req, bus.en, bus.gnt_valid, bus.gnt_idx, bus.preempt);
            checks++;
            assert (bus.gnt_valid === e.v) else begin
                errors++;
                $error("FAIL %s gnt_valid: got %b expected %b", e.tag, bus.gnt_valid, e.v);
            end
            checks++;
            assert (bus.gnt_idx === e.i) else begin
                errors++;
                $error("FAIL %s gnt_idx: got %0d expected %0d", e.tag, bus.gnt_idx, e.i);
            end
            checks++;
            assert (bus.preempt === e.p) else begin
                errors++;
                $error("FAIL %s preempt: got %b expected %b", e.tag, bus.preempt, e.p);
            end
        end
    endtask

    // Drive inputs off-edge, queue the expected result of the next edge, then check it.
    task automatic cyc(input logic [3:0] r, input logic e, input logic v, input logic [1:0] i,
                       input logic p, input string tag);
        bus.req = r;
        bus.en  = e;
        push_exp(tag, v, i, p);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic pulse_reset(input logic [3:0] r);
        bus.req = r;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req = 4'b1111;
        bus.en  = 1'b1;
        rst_n   = 1'b0;

        // T1: reset held with all requests active
        repeat (3) @(posedge clk);
        #1;
        push_exp("t1_reset", 1'b0, 2'd0, 1'b0);
        pop_check();
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t1_idle");

        // T3: rotation, each owner holds 3 clk then drops its bit for 1 clk
        cyc(4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, "t3_first");
        for (int k = 0; k < 4; k++) begin
            logic [3:0] drop;
            drop = 4'b1111 & ~(4'b0001 << k);
            cyc(4'b1111, 1'b1, 1'b1, 2'(k), 1'b0, "t3_hold");
            cyc(4'b1111, 1'b1, 1'b1, 2'(k), 1'b0, "t3_hold");
            cyc(drop, 1'b1, 1'b1, 2'((k + 1) % 4), 1'b0, "t3_handoff");
        end
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t3_release");

        // T2: single request, ptr now 0
        cyc(4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, "t2_grant");
        cyc(4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, "t2_release");

        // T4: enable gating
        for (int k = 0; k < 10; k++) begin
            cyc(4'b0010, 1'b0, 1'b0, 2'd2, 1'b0, "t4_disabled");
        end
        cyc(4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, "t4_enable");
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, "t4_hold_en0");
        end
        cyc(4'b1000, 1'b0, 1'b0, 2'd1, 1'b0, "t4_release_en0");

        // T5: reset mid-grant; ptr=1 so without reset 1001 would go to 3
        cyc(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "t5_grant3");
        cyc(4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, "t5_hold3");
        bus.req = 4'b1001;
        rst_n   = 1'b0;
        #1;
        push_exp("t5_async_drop", 1'b0, 2'd0, 1'b0);
        pop_check();
        @(posedge clk);
        #1;
        push_exp("t5_in_reset", 1'b0, 2'd0, 1'b0);
        pop_check();
        rst_n = 1'b1;
        cyc(4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, "t5_restart");
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t5_release");

        // T6: hold limit (forced rotation only with the macro)
        pulse_reset(4'b0000);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0011, 1'b1, 1'b1, 2'd0, 1'b0, "t6_owner0");
        end
        cyc(4'b0011, 1'b1, 1'b1, HOLD_EN ? 2'd1 : 2'd0, HOLD_EN, "t6_limit");
        cyc(4'b0011, 1'b1, 1'b1, HOLD_EN ? 2'd1 : 2'd0, 1'b0, "t6_after");
        cyc(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "t6_back0");
        for (int k = 0; k < 8; k++) begin
            cyc(4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, "t6_alone_kept");
        end
        cyc(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, "t6_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
